bellek_hakemi: RTL and testbench
================================

// Module: bellek_hakemi
// PURPOSE
//  Arbitrates the single main-memory burst port between the instruction cache (buyruk, read-only line fills)
//  and the data cache (veri, line fills and write-backs). Sits between both caches and the main memory/AXI
//  bridge. Round-robin grant, one burst of KELIME_SAYISI 32-bit beats per grant.
// PARAMETERS
//  KELIME_SAYISI  8    beats per burst (power of 2, >=2)
//  ZAMAN_ASIMI    255  max wait cycles per beat (used only with BELLEK_HAKEMI_ZAMAN_ASIMI_EN)
// PORTS
//  clk_i                 in   1   clock
//  rst_i                 in   1   asynchronous reset, active-low
//  bb_istek_i            in   1   instruction-cache burst request (held until bb_bitti_o)
//  bb_adres_i            in   32  instruction burst base address (line aligned)
//  bb_veri_o             out  32  read beat data to instruction cache
//  bb_veri_gecerli_o     out  1   bb_veri_o valid this cycle
//  bb_bitti_o            out  1   last beat of instruction burst completes this cycle
//  vb_istek_i            in   1   data-cache burst request (held until vb_bitti_o)
//  vb_yaz_i              in   1   1 = write-back burst, 0 = fill
//  vb_adres_i            in   32  data burst base address (line aligned)
//  vb_yazma_veri_i       in   32  current write beat data
//  vb_yazma_veri_al_o    out  1   current write beat consumed; present next beat next cycle
//  vb_veri_o             out  32  read beat data to data cache
//  vb_veri_gecerli_o     out  1   vb_veri_o valid this cycle
//  vb_bitti_o            out  1   last beat of data burst completes this cycle
//  kelime_sira_o         out  log2(KELIME_SAYISI)  index of current beat
//  abellek_istek_o       out  1   beat request to main memory
//  abellek_yaz_o         out  1   beat is a write
//  abellek_adres_o       out  32  beat address
//  abellek_yazma_veri_o  out  32  write beat data
//  abellek_hazir_i       in   1   beat handshake: write accepted / read data valid
//  abellek_okunan_veri_i in   32  read beat data
//  hata_o                out  1   beat timeout pulse (only with BELLEK_HAKEMI_ZAMAN_ASIMI_EN)
// BEHAVIOUR
//  - States: BOSTA, BB_AKTAR, VB_AKTAR. Reset: BOSTA, beat counter 0, son_hizmet=BB, all outputs 0.
//  - BOSTA: only one istek -> grant it; both -> grant side opposite son_hizmet. Grant latches base address,
//    vb_yaz_i; next cycle enters *_AKTAR (1-cycle idle-to-first-beat latency). Not in BOSTA: istek ignored.
//  - *_AKTAR: abellek_istek_o=1; abellek_adres_o = base + 4*kelime_sira_o (32-bit wrap, no carry out);
//    abellek_yaz_o = latched yaz (always 0 in BB_AKTAR). Beat done when abellek_istek_o && abellek_hazir_i.
//  - Read beat: granted side's *_veri_o = abellek_okunan_veri_i, *_veri_gecerli_o=1 same cycle (combinational).
//  - Write beat: abellek_yazma_veri_o = vb_yazma_veri_i (pass-through); vb_yazma_veri_al_o=1 on handshake.
//  - Counter increments per handshake; last beat (KELIME_SAYISI-1) handshake: *_bitti_o=1 same cycle,
//    counter -> 0, son_hizmet <= granted side, state -> BOSTA. Requester drops istek by next cycle;
//    istek still high in BOSTA counts as a new request.
//  - abellek_hazir_i low: hold all beat outputs stable, no counter change; no beat limit without the macro.
//  - Non-granted side outputs always 0. Dropping istek mid-burst does not abort the burst.
//  - Async reset mid-burst: immediate return to reset state; partial burst discarded, no bitti pulse.
// CONFIGURATION
//  BELLEK_HAKEMI_ZAMAN_ASIMI_EN defined: per-beat wait counter (reset on each handshake and on grant);
//    reaching ZAMAN_ASIMI without handshake -> hata_o=1 and granted *_bitti_o=1 for one cycle, burst
//    aborted, counter 0, son_hizmet updated, state -> BOSTA. hata_o reset 0.
//  Not defined: no wait counter, hata_o tied 0, bursts wait indefinitely.
// TESTING
//  1 bb only, adres 0x1000, hazir_i always 1 -> 8 beats at 0x1000..0x101C, bb_bitti_o on beat 7, vb_* outputs 0.
//  2 bb and vb raised same cycle after reset -> VB granted first, then BB; next tie goes to VB again.
//  3 vb write-back, adres 0x2000, data 0xA0..0xA7, hazir_i toggling 1/0 -> 8 writes in order, al_o once each.
//  4 base 0xFFFFFFF0, bb burst -> addresses ...F0..FC then 0x00000000..0x0000000C (wrap), no hang.
//  5 rst_i low at beat 3 of vb fill -> all outputs 0 next edge, BOSTA, new bb request granted with counter 0.
//  6 macro on, ZAMAN_ASIMI=4, hazir_i stuck 0 on beat 2 -> hata_o and vb_bitti_o one-cycle pulse, then BOSTA.

Source files
------------

// File: rtl/bellek_hakemi.sv
// bellek_hakemi
//   Arbitrates the single main-memory burst port between the instruction
//   cache (buyruk, read-only line fills) and the data cache (veri, fills and
//   write-backs). Round-robin grant; one burst of KELIME_SAYISI 32-bit beats
//   per grant.
//
//   Optional feature macro: BELLEK_HAKEMI_ZAMAN_ASIMI_EN
//     defined   -> per-beat wait counter; a beat that waits ZAMAN_ASIMI cycles
//                  without handshake aborts the burst (hata_o + *_bitti_o pulse)
//     undefined -> no wait counter, hata_o tied 0, bursts wait indefinitely
//
//   Ports
//     clk_i, rst_i (async, active-low)
//     bb_*      instruction-cache request / address / read data / done
//     vb_*      data-cache request / write flag / address / write data /
//               write-data accept / read data / done
//     kelime_sira_o  index of the current beat
//     abellek_* main-memory beat request / write / address / write data /
//               handshake / read data
//     hata_o    beat timeout pulse
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   BOSTA    | idle, arbitrating between bb and vb requests
//   BB_AKTAR | instruction-cache fill burst in progress
//   VB_AKTAR | data-cache fill or write-back burst in progress

module bellek_hakemi #(
    parameter int KELIME_SAYISI = 8,
    parameter int ZAMAN_ASIMI   = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             bb_istek_i,
    input  logic [31:0]                      bb_adres_i,
    output logic [31:0]                      bb_veri_o,
    output logic                             bb_veri_gecerli_o,
    output logic                             bb_bitti_o,
    input  logic                             vb_istek_i,
    input  logic                             vb_yaz_i,
    input  logic [31:0]                      vb_adres_i,
    input  logic [31:0]                      vb_yazma_veri_i,
    output logic                             vb_yazma_veri_al_o,
    output logic [31:0]                      vb_veri_o,
    output logic                             vb_veri_gecerli_o,
    output logic                             vb_bitti_o,
    output logic [$clog2(KELIME_SAYISI)-1:0] kelime_sira_o,
    output logic                             abellek_istek_o,
    output logic                             abellek_yaz_o,
    output logic [31:0]                      abellek_adres_o,
    output logic [31:0]                      abellek_yazma_veri_o,
    input  logic                             abellek_hazir_i,
    input  logic [31:0]                      abellek_okunan_veri_i,
    output logic                             hata_o
);

    localparam int SW = $clog2(KELIME_SAYISI);
    localparam logic [SW-1:0] SON_SIRA = SW'(KELIME_SAYISI - 1);

    typedef enum logic [1:0] {
        BOSTA    = 2'd0,
        BB_AKTAR = 2'd1,
        VB_AKTAR = 2'd2
    } durum_t;

    durum_t         r_durum;
    logic [31:0]    r_taban;
    logic           r_yaz;
    logic           r_son_bb;   // 1: last completed burst served bb
    logic [SW-1:0]  r_sira;

    logic           w_aktar;
    logic           w_bb;
    logic           w_vb;
    logic           w_vb_yaz;
    logic           w_el;
    logic           w_son_kelime;
    logic           w_zaman_doldu;
    logic           w_bitti;
    logic           w_bb_gecerli;
    logic           w_vb_gecerli;
    logic [31:0]    w_ofset;

    assign w_aktar      = (r_durum != BOSTA);
    assign w_bb         = (r_durum == BB_AKTAR);
    assign w_vb         = (r_durum == VB_AKTAR);
    assign w_vb_yaz     = w_vb && r_yaz;
    assign w_el         = w_aktar && abellek_hazir_i;
    assign w_son_kelime = (r_sira == SON_SIRA);
    assign w_bitti      = (w_el && w_son_kelime) || w_zaman_doldu;
    assign w_ofset      = {{(30-SW){1'b0}}, r_sira, 2'b00};
    assign w_bb_gecerli = w_bb && abellek_hazir_i;
    assign w_vb_gecerli = w_vb && !r_yaz && abellek_hazir_i;

`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
    localparam int BW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [BW-1:0] BEKLE_YUK = BW'(ZAMAN_ASIMI - 1);

    // Down-counter of remaining wait cycles for the current beat; reloaded
    // while idle (covers the grant) and on every handshake.
    logic [BW-1:0] r_bekle;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bekle <= '0;
        end else if (!w_aktar || w_el) begin
            r_bekle <= BEKLE_YUK;
        end else if (r_bekle != '0) begin
            r_bekle <= r_bekle - 1'b1;
        end
    end

    assign w_zaman_doldu = w_aktar && !abellek_hazir_i && (r_bekle == '0);
`else
    assign w_zaman_doldu = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_durum  <= BOSTA;
            r_taban  <= '0;
            r_yaz    <= 1'b0;
            r_son_bb <= 1'b1;
            r_sira   <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    // On a tie, serve the side that was not served last.
                    if (vb_istek_i && (!bb_istek_i || r_son_bb)) begin
                        r_durum <= VB_AKTAR;
                        r_taban <= vb_adres_i;
                        r_yaz   <= vb_yaz_i;
                    end else if (bb_istek_i) begin
                        r_durum <= BB_AKTAR;
                        r_taban <= bb_adres_i;
                        r_yaz   <= 1'b0;
                    end
                end
                BB_AKTAR, VB_AKTAR: begin
                    if (w_bitti) begin
                        r_durum  <= BOSTA;
                        r_sira   <= '0;
                        r_son_bb <= w_bb;
                    end else if (w_el) begin
                        r_sira <= r_sira + 1'b1;
                    end
                end
                default: begin
                    r_durum <= BOSTA;
                end
            endcase
        end
    end

    assign kelime_sira_o        = r_sira;
    assign abellek_istek_o      = w_aktar;
    assign abellek_yaz_o        = w_vb_yaz;
    assign abellek_adres_o      = w_aktar ? (r_taban + w_ofset) : 32'd0;
    assign abellek_yazma_veri_o = w_vb_yaz ? vb_yazma_veri_i : 32'd0;

    assign bb_veri_gecerli_o    = w_bb_gecerli;
    assign bb_veri_o            = w_bb_gecerli ? abellek_okunan_veri_i : 32'd0;
    assign bb_bitti_o           = w_bb && w_bitti;

    assign vb_veri_gecerli_o    = w_vb_gecerli;
    assign vb_veri_o            = w_vb_gecerli ? abellek_okunan_veri_i : 32'd0;
    assign vb_yazma_veri_al_o   = w_vb_yaz && abellek_hazir_i;
    assign vb_bitti_o           = w_vb && w_bitti;

    assign hata_o               = w_zaman_doldu;

endmodule

// File: tb/tb_bellek_hakemi.sv
module tb_bellek_hakemi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bb_istek_i;
    logic [31:0] bb_adres_i;
    logic [31:0] bb_veri_o;
    logic        bb_veri_gecerli_o;
    logic        bb_bitti_o;
    logic        vb_istek_i;
    logic        vb_yaz_i;
    logic [31:0] vb_adres_i;
    logic [31:0] vb_yazma_veri_i;
    logic        vb_yazma_veri_al_o;
    logic [31:0] vb_veri_o;
    logic        vb_veri_gecerli_o;
    logic        vb_bitti_o;
    logic [2:0]  kelime_sira_o;
    logic        abellek_istek_o;
    logic        abellek_yaz_o;
    logic [31:0] abellek_adres_o;
    logic [31:0] abellek_yazma_veri_o;
    logic        abellek_hazir_i;
    logic [31:0] abellek_okunan_veri_i;
    logic        hata_o;

    int total = 0;
    int bad   = 0;

    bellek_hakemi #(.KELIME_SAYISI(8), .ZAMAN_ASIMI(4)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .bb_istek_i            (bb_istek_i),
        .bb_adres_i            (bb_adres_i),
        .bb_veri_o             (bb_veri_o),
        .bb_veri_gecerli_o     (bb_veri_gecerli_o),
        .bb_bitti_o            (bb_bitti_o),
        .vb_istek_i            (vb_istek_i),
        .vb_yaz_i              (vb_yaz_i),
        .vb_adres_i            (vb_adres_i),
        .vb_yazma_veri_i       (vb_yazma_veri_i),
        .vb_yazma_veri_al_o    (vb_yazma_veri_al_o),
        .vb_veri_o             (vb_veri_o),
        .vb_veri_gecerli_o     (vb_veri_gecerli_o),
        .vb_bitti_o            (vb_bitti_o),
        .kelime_sira_o         (kelime_sira_o),
        .abellek_istek_o       (abellek_istek_o),
        .abellek_yaz_o         (abellek_yaz_o),
        .abellek_adres_o       (abellek_adres_o),
        .abellek_yazma_veri_o  (abellek_yazma_veri_o),
        .abellek_hazir_i       (abellek_hazir_i),
        .abellek_okunan_veri_i (abellek_okunan_veri_i),
        .hata_o                (hata_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_veri(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check_idle(input string ad);
        total++;
        if ({abellek_istek_o, bb_veri_gecerli_o, vb_veri_gecerli_o, bb_bitti_o, vb_bitti_o,
             vb_yazma_veri_al_o, abellek_yaz_o, hata_o} !== 8'b0) begin
            bad++;
            $display("FAIL %s: control outputs got %b required 00000000", ad,
                     {abellek_istek_o, bb_veri_gecerli_o, vb_veri_gecerli_o, bb_bitti_o, vb_bitti_o,
                      vb_yazma_veri_al_o, abellek_yaz_o, hata_o});
        end
        total++;
        if ({abellek_adres_o, abellek_yazma_veri_o, bb_veri_o, vb_veri_o, kelime_sira_o} !== '0) begin
            bad++;
            $display("FAIL %s: adres=%h wdata=%h bb=%h vb=%h sira=%0d required all 0", ad,
                     abellek_adres_o, abellek_yazma_veri_o, bb_veri_o, vb_veri_o, kelime_sira_o);
        end
    endtask

    // Called at a negedge where the DUT is idle and the request is already
    // driven; runs one full read burst with hazir=1 and checks every beat.
    task automatic do_read(input bit is_vb, input logic [31:0] taban, input string ad);
        logic [31:0] a;
        logic g_gec, g_bit, o_gec, o_bit;
        logic [31:0] g_veri;
        abellek_hazir_i = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            a = taban + 32'(4 * k);
            abellek_okunan_veri_i = mem_veri(a);
            #1;
            g_gec  = is_vb ? vb_veri_gecerli_o : bb_veri_gecerli_o;
            g_bit  = is_vb ? vb_bitti_o : bb_bitti_o;
            g_veri = is_vb ? vb_veri_o : bb_veri_o;
            o_gec  = is_vb ? bb_veri_gecerli_o : vb_veri_gecerli_o;
            o_bit  = is_vb ? bb_bitti_o : vb_bitti_o;
            total++;
            if (abellek_istek_o !== 1'b1 || abellek_yaz_o !== 1'b0) begin
                bad++;
                $display("FAIL %s istek/yaz beat %0d: got %b%b required 10", ad, k, abellek_istek_o, abellek_yaz_o);
            end
            total++;
            if (abellek_adres_o !== a) begin
                bad++;
                $display("FAIL %s adres beat %0d: got %h required %h", ad, k, abellek_adres_o, a);
            end
            total++;
            if (kelime_sira_o !== 3'(k)) begin
                bad++;
                $display("FAIL %s sira beat %0d: got %0d required %0d", ad, k, kelime_sira_o, k);
            end
            total++;
            if (g_gec !== 1'b1 || g_veri !== mem_veri(a)) begin
                bad++;
                $display("FAIL %s veri beat %0d: got gec=%b %h required gec=1 %h", ad, k, g_gec, g_veri, mem_veri(a));
            end
            total++;
            if (g_bit !== (k == 7)) begin
                bad++;
                $display("FAIL %s bitti beat %0d: got %b required %b", ad, k, g_bit, (k == 7));
            end
            total++;
            if (o_gec !== 1'b0 || o_bit !== 1'b0 || vb_yazma_veri_al_o !== 1'b0) begin
                bad++;
                $display("FAIL %s other side beat %0d: got gec=%b bitti=%b al=%b required 000", ad, k, o_gec, o_bit, vb_yazma_veri_al_o);
            end
            if (k == 7) begin
                if (is_vb) vb_istek_i = 1'b0;
                else       bb_istek_i = 1'b0;
            end else begin
                @(negedge clk_i);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        bb_istek_i = 0; bb_adres_i = 0; vb_istek_i = 0; vb_yaz_i = 0; vb_adres_i = 0;
        vb_yazma_veri_i = 32'hDEAD_BEEF; abellek_hazir_i = 1; abellek_okunan_veri_i = 32'h1234_5678;
        repeat (2) @(negedge clk_i);
        check_idle("reset_active");
        rst_i = 1'b1;
        @(negedge clk_i);
        check_idle("after_reset");
    endtask

    task automatic test_bb_only();
        bb_adres_i = 32'h0000_1000; bb_istek_i = 1'b1;
        do_read(1'b0, 32'h0000_1000, "bb_only");
        @(negedge clk_i);
        check_idle("bb_only_idle");
    endtask

    task automatic test_tie();
        // Both raised together right after a bb burst: last served = bb, so vb wins.
        bb_adres_i = 32'h0000_4000; vb_adres_i = 32'h0000_3000; vb_yaz_i = 1'b0;
        bb_istek_i = 1'b1; vb_istek_i = 1'b1;
        do_read(1'b1, 32'h0000_3000, "tie_vb_first");
        @(negedge clk_i);
        check_idle("tie_gap");
        do_read(1'b0, 32'h0000_4000, "tie_bb_second");
        @(negedge clk_i);
        check_idle("tie_gap2");
        bb_adres_i = 32'h0000_6100; vb_adres_i = 32'h0000_5000;
        bb_istek_i = 1'b1; vb_istek_i = 1'b1;
        do_read(1'b1, 32'h0000_5000, "tie_vb_again");
        bb_istek_i = 1'b0;
        // bb request dropped at the last vb beat, so nothing is granted next.
        @(negedge clk_i);
        @(negedge clk_i);
        check_idle("tie_done");
    endtask

    task automatic test_write_back();
        int j = 0;
        vb_adres_i = 32'h0000_2000; vb_yaz_i = 1'b1; vb_istek_i = 1'b1;
        abellek_hazir_i = 1'b0;
        @(negedge clk_i);
        for (int c = 0; c < 40 && j < 8; c++) begin
            abellek_hazir_i = (c % 2 == 0);
            vb_yazma_veri_i = 32'hA0 + 32'(j);
            #1;
            total++;
            if (abellek_istek_o !== 1'b1 || abellek_yaz_o !== 1'b1) begin
                bad++;
                $display("FAIL wb istek/yaz cyc %0d: got %b%b required 11", c, abellek_istek_o, abellek_yaz_o);
            end
            total++;
            if (abellek_adres_o !== 32'h2000 + 32'(4 * j) || kelime_sira_o !== 3'(j)) begin
                bad++;
                $display("FAIL wb adres cyc %0d: got %h sira %0d required %h sira %0d", c,
                         abellek_adres_o, kelime_sira_o, 32'h2000 + 32'(4 * j), j);
            end
            total++;
            if (abellek_yazma_veri_o !== 32'hA0 + 32'(j)) begin
                bad++;
                $display("FAIL wb wdata cyc %0d: got %h required %h", c, abellek_yazma_veri_o, 32'hA0 + 32'(j));
            end
            total++;
            if (vb_yazma_veri_al_o !== abellek_hazir_i || vb_veri_gecerli_o !== 1'b0) begin
                bad++;
                $display("FAIL wb al cyc %0d: got al=%b gec=%b required al=%b gec=0", c,
                         vb_yazma_veri_al_o, vb_veri_gecerli_o, abellek_hazir_i);
            end
            total++;
            if (vb_bitti_o !== (abellek_hazir_i && j == 7)) begin
                bad++;
                $display("FAIL wb bitti cyc %0d: got %b required %b", c, vb_bitti_o, (abellek_hazir_i && j == 7));
            end
            if (abellek_hazir_i) j++;
            if (j == 8) vb_istek_i = 1'b0;
            else        @(negedge clk_i);
        end
        total++;
        if (j != 8) begin
            bad++;
            $display("FAIL wb timeout: beats got %0d required 8", j);
            vb_istek_i = 1'b0;
        end
        vb_yaz_i = 1'b0;
        abellek_hazir_i = 1'b1;
        @(negedge clk_i);
        check_idle("wb_idle");
    endtask

    task automatic test_wrap();
        bb_adres_i = 32'hFFFF_FFF0; bb_istek_i = 1'b1;
        do_read(1'b0, 32'hFFFF_FFF0, "wrap");
        @(negedge clk_i);
        check_idle("wrap_idle");
    endtask

    task automatic test_reset_mid();
        vb_adres_i = 32'h0000_6000; vb_yaz_i = 1'b0; vb_istek_i = 1'b1; abellek_hazir_i = 1'b1;
        repeat (4) @(negedge clk_i);
        total++;
        if (kelime_sira_o !== 3'd3 || vb_veri_gecerli_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid pre: got sira=%0d gec=%b required sira=3 gec=1", kelime_sira_o, vb_veri_gecerli_o);
        end
        rst_i = 1'b0;
        vb_istek_i = 1'b0;
        #1;
        check_idle("rstmid_async");
        @(negedge clk_i);
        rst_i = 1'b1;
        bb_adres_i = 32'h0000_7000; bb_istek_i = 1'b1;
        do_read(1'b0, 32'h0000_7000, "rstmid_bb");
        @(negedge clk_i);
        check_idle("rstmid_idle");
    endtask

`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
    task automatic test_timeout();
        vb_adres_i = 32'h0000_9000; vb_yaz_i = 1'b0; vb_istek_i = 1'b1; abellek_hazir_i = 1'b1;
        repeat (3) @(negedge clk_i);
        abellek_hazir_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            #1;
            total++;
            if (hata_o !== (w == 3) || vb_bitti_o !== (w == 3) || kelime_sira_o !== 3'd2) begin
                bad++;
                $display("FAIL timeout wait %0d: got hata=%b bitti=%b sira=%0d required %b %b 2", w,
                         hata_o, vb_bitti_o, kelime_sira_o, (w == 3), (w == 3));
            end
            if (w == 3) vb_istek_i = 1'b0;
            @(negedge clk_i);
        end
        check_idle("timeout_idle");
        abellek_hazir_i = 1'b1;
    endtask
`else
    task automatic test_timeout();
        bb_adres_i = 32'h0000_8000; bb_istek_i = 1'b1; abellek_hazir_i = 1'b0;
        @(negedge clk_i);
        for (int w = 0; w < 300; w++) begin
            #1;
            total++;
            if (abellek_istek_o !== 1'b1 || abellek_adres_o !== 32'h8000 || kelime_sira_o !== 3'd0 ||
                hata_o !== 1'b0 || bb_bitti_o !== 1'b0 || bb_veri_gecerli_o !== 1'b0) begin
                bad++;
                $display("FAIL stall cyc %0d: got istek=%b adres=%h sira=%0d hata=%b bitti=%b gec=%b required 1 8000 0 0 0 0",
                         w, abellek_istek_o, abellek_adres_o, kelime_sira_o, hata_o, bb_bitti_o, bb_veri_gecerli_o);
            end
            @(negedge clk_i);
        end
        abellek_hazir_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            abellek_okunan_veri_i = mem_veri(32'h8000 + 32'(4 * k));
            #1;
            total++;
            if (bb_bitti_o !== (k == 7) || bb_veri_o !== mem_veri(32'h8000 + 32'(4 * k))) begin
                bad++;
                $display("FAIL stall resume beat %0d: got bitti=%b veri=%h required %b %h", k, bb_bitti_o,
                         bb_veri_o, (k == 7), mem_veri(32'h8000 + 32'(4 * k)));
            end
            if (k == 7) bb_istek_i = 1'b0;
            @(negedge clk_i);
        end
        check_idle("stall_idle");
    endtask
`endif

    initial begin
        test_reset();
        test_bb_only();
        test_tie();
        test_write_back();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
